// File: rtl/gray_codec_pkg.sv
// Shared mode and output-state encodings for the Gray codec.
// Mode values match the 2-bit mode port; state values are the output register occupancy.
package gray_codec_pkg;

  typedef enum logic [1:0] {
    MODE_G2B   = 2'b00,
    MODE_B2G   = 2'b01,
    MODE_COUNT = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/gray2bin_n.sv
// Combinational Gray-to-binary converter, WIDTH-parametrised.
// Zero latency; no flow control.
module gray2bin_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the running XOR of the Gray bits from the MSB down.
  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/gray_codec_seq.sv
// Gray codec with convert/count/load modes and a single registered output slot, latency 1.
// in_ready drops while the result is stalled (out_ready=0) or during reset; accept-and-drain in one cycle.
module gray_codec_seq
  import gray_codec_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             up,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  mode_t            mode_sel;
  logic             accept;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] g2b_bin;

  assign mode_sel = mode_t'(mode);
  assign in_ready = ((state == ST_EMPTY) || out_ready) && !rst;
  assign accept   = in_valid && in_ready;

  gray2bin_n #(.WIDTH(WIDTH)) u_g2b (
    .gray (in_data),
    .bin  (g2b_bin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == ST_FULL);
  end

  // Counter only moves on COUNT/LOAD; conversions leave it untouched.
  always_comb begin
    cnt_nxt = cnt;
    result  = '0;
    case (mode_sel)
      MODE_G2B: result = g2b_bin;
      MODE_B2G: result = in_data ^ (in_data >> 1);
      MODE_COUNT: begin
        cnt_nxt = up ? (cnt + ONE) : (cnt - ONE);
        result  = cnt_nxt ^ (cnt_nxt >> 1);
      end
      MODE_LOAD: begin
        cnt_nxt = in_data;
        result  = in_data ^ (in_data >> 1);
      end
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      out_data <= '0;
    end else if (accept) begin
      cnt      <= cnt_nxt;
      out_data <= result;
    end
  end

endmodule

// File: tb/tb_gray_codec_seq.sv
// Scoreboard bench for gray_codec_seq at WIDTH=4: expected results queued at accept, checked at output.
module tb_gray_codec_seq;
  import gray_codec_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic         up = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] cnt_m = '0;
  logic [W-1:0] exp_v;

  gray_codec_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .up        (up),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] b2g_m(input logic [W-1:0] b);
    return b ^ {1'b0, b[W-1:1]};
  endfunction

  function automatic logic [W-1:0] g2b_m(input logic [W-1:0] g);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  function automatic logic [W-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] m, input logic u, input logic [W-1:0] d);
    in_valid = 1'b1;
    mode     = m;
    up       = u;
    in_data  = d;
  endtask

  // Model of one accepted beat: updates the bench counter and queues the expected result.
  task automatic push_exp(input logic [1:0] m, input logic u, input logic [W-1:0] d);
    case (m)
      2'b00: exp_q.push_back(g2b_m(d));
      2'b01: exp_q.push_back(b2g_m(d));
      2'b10: begin
        cnt_m = u ? cnt_m + 4'd1 : cnt_m - 4'd1;
        exp_q.push_back(b2g_m(cnt_m));
      end
      default: begin
        cnt_m = d;
        exp_q.push_back(b2g_m(d));
      end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    exp_q.delete();
    cnt_m = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    offer(MODE_LOAD, 1'b0, 4'b1010);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    step();
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (out_data !== 4'b0000) begin tests_failed++; $display("FAIL reset_out_data got %b want 0000", out_data); end
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_beat_dropped got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_convert();
    out_ready = 1'b1;
    offer(MODE_G2B, 1'b0, 4'b1011);
    exp_q.push_back(4'b1101);
    step();
    exp_v = pop_exp();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== exp_v) begin
      tests_failed++; $display("FAIL g2b_1011 got v=%b d=%b want v=1 d=%b", out_valid, out_data, exp_v);
    end
    offer(MODE_B2G, 1'b0, 4'b1101);
    exp_q.push_back(4'b1011);
    step();
    exp_v = pop_exp();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== exp_v) begin
      tests_failed++; $display("FAIL b2g_1101 got v=%b d=%b want v=1 d=%b", out_valid, out_data, exp_v);
    end
    for (int k = 0; k < 16; k++) begin
      offer(k[0] ? MODE_B2G : MODE_G2B, 1'b0, W'($urandom_range(0, 15)));
      push_exp(mode, up, in_data);
      step();
      exp_v = pop_exp();
      tests_run++;
      if (out_data !== exp_v) begin
        tests_failed++; $display("FAIL convert_rand mode=%b in=%b got %b want %b", mode, in_data, out_data, exp_v);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_load_count();
    out_ready = 1'b1;
    offer(MODE_LOAD, 1'b0, 4'b1111);
    push_exp(MODE_LOAD, 1'b0, 4'b1111);
    step();
    exp_v = pop_exp();
    tests_run++;
    if (out_data !== 4'b1000 || out_data !== exp_v) begin
      tests_failed++; $display("FAIL load_1111 got %b want 1000", out_data);
    end
    // A conversion in between must leave the loaded counter alone.
    offer(MODE_B2G, 1'b0, 4'b0110);
    push_exp(MODE_B2G, 1'b0, 4'b0110);
    step();
    exp_v = pop_exp();
    tests_run++;
    if (out_data !== exp_v) begin tests_failed++; $display("FAIL b2g_between got %b want %b", out_data, exp_v); end
    offer(MODE_COUNT, 1'b1, 4'b1010);
    push_exp(MODE_COUNT, 1'b1, 4'b1010);
    step();
    exp_v = pop_exp();
    tests_run++;
    if (out_data !== 4'b0000 || out_data !== exp_v) begin
      tests_failed++; $display("FAIL count_wrap_up got %b want 0000", out_data);
    end
    push_exp(MODE_COUNT, 1'b1, 4'b0000);
    step();
    exp_v = pop_exp();
    tests_run++;
    if (out_data !== 4'b0001 || out_data !== exp_v) begin
      tests_failed++; $display("FAIL count_up_1 got %b want 0001", out_data);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_count_walk();
    logic [W-1:0] prev;
    logic [15:0]  seen;
    do_reset();
    out_ready = 1'b1;
    offer(MODE_COUNT, 1'b0, 4'b0101);
    push_exp(MODE_COUNT, 1'b0, 4'b0101);
    step();
    exp_v = pop_exp();
    tests_run++;
    if (out_data !== 4'b1000 || out_data !== exp_v) begin
      tests_failed++; $display("FAIL count_wrap_down got %b want 1000", out_data);
    end
    prev = out_data;
    seen = '0;
    for (int k = 0; k < 16; k++) begin
      push_exp(MODE_COUNT, 1'b0, 4'b0000);
      step();
      exp_v = pop_exp();
      tests_run++;
      if (out_data !== exp_v || $countones(out_data ^ prev) != 1) begin
        tests_failed++; $display("FAIL walk_step%0d got %b prev %b want %b", k, out_data, prev, exp_v);
      end
      seen[out_data] = 1'b1;
      prev = out_data;
    end
    tests_run++;
    if (seen !== 16'hFFFF || out_data !== 4'b1000) begin
      tests_failed++; $display("FAIL walk_cover got seen=%h last=%b want ffff/1000", seen, out_data);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    offer(MODE_LOAD, 1'b0, 4'b0101);
    push_exp(MODE_LOAD, 1'b0, 4'b0101);
    step();
    out_ready = 1'b0;
    offer(MODE_G2B, 1'b0, 4'b0110);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_in_ready cyc%0d got %b want 0", k, in_ready); end
      step();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
        tests_failed++; $display("FAIL stall_hold cyc%0d got v=%b d=%b want v=1 d=%b", k, out_valid, out_data, exp_q[0]);
      end
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
    void'(pop_exp());
    push_exp(MODE_G2B, 1'b0, 4'b0110);
    step();
    exp_v = pop_exp();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 4'b0100 || out_data !== exp_v) begin
      tests_failed++; $display("FAIL stall_second got v=%b d=%b want v=1 d=0100", out_valid, out_data);
    end
    in_valid = 1'b0;
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] m;
    out_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      m = 2'($urandom_range(0, 3));
      offer(m, 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)));
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready beat%0d got %b want 1", k, in_ready); end
      push_exp(mode, up, in_data);
      step();
      exp_v = pop_exp();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== exp_v) begin
        tests_failed++; $display("FAIL b2b_beat%0d mode=%b got v=%b d=%b want v=1 d=%b", k, m, out_valid, out_data, exp_v);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    offer(MODE_LOAD, 1'b0, 4'b1001);
    push_exp(MODE_LOAD, 1'b0, 4'b1001);
    step();
    out_ready = 1'b0;
    offer(MODE_COUNT, 1'b1, 4'b0000);
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 4'b0000) begin
      tests_failed++; $display("FAIL midrst_clear got v=%b d=%b want v=0 d=0000", out_valid, out_data);
    end
    exp_q.delete();
    cnt_m = '0;
    rst = 1'b0;
    out_ready = 1'b1;
    offer(MODE_COUNT, 1'b1, 4'b0000);
    push_exp(MODE_COUNT, 1'b1, 4'b0000);
    step();
    exp_v = pop_exp();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 4'b0001 || out_data !== exp_v) begin
      tests_failed++; $display("FAIL midrst_count got v=%b d=%b want v=1 d=0001", out_valid, out_data);
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_convert();
    test_load_count();
    test_count_walk();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
